// File: rtl/minn_window_sum.sv
// Sliding-window accumulator for the Minn timing metric: adds the newest term and
// subtracts the term the delay line reports as leaving the window.
module minn_window_sum #(
    parameter int WIDTH        = 16,
    parameter int WINDOW       = 16,
    parameter int ACC_WIDTH    = WIDTH + $clog2(WINDOW) + 1,
    parameter bit EMIT_PARTIAL = 1'b0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clear,
    input  logic                        in_valid,
    input  logic signed [WIDTH-1:0]     in_data,
    input  logic                        old_valid,
    input  logic signed [WIDTH-1:0]     old_data,
    output logic                        out_valid,
    output logic signed [ACC_WIDTH-1:0] out_sum,
    output logic                        window_full,
    output logic                        err
);
    localparam int CW = (WINDOW > 0) ? $clog2(WINDOW + 1) : 1;

    if (WINDOW <= 0) begin : g_bad_window
        $error("minn_window_sum: WINDOW must be positive");
    end
    if (ACC_WIDTH < WIDTH + $clog2(WINDOW)) begin : g_bad_acc
        $error("minn_window_sum: ACC_WIDTH too narrow for WINDOW terms");
    end

    logic signed [ACC_WIDTH-1:0] acc;
    logic signed [ACC_WIDTH-1:0] acc_next;
    logic signed [ACC_WIDTH-1:0] in_ext;
    logic signed [ACC_WIDTH-1:0] old_ext;
    logic        [CW-1:0]        count;
    logic        [CW-1:0]        count_next;
    logic                        full_now;
    logic                        sub;

    assign in_ext  = ACC_WIDTH'(in_data);
    assign old_ext = ACC_WIDTH'(old_data);

    // Subtraction only once the window holds WINDOW terms; earlier departing
    // terms are a protocol error and must not disturb the running sum.
    assign full_now   = (count == CW'(WINDOW));
    assign sub        = old_valid && full_now;
    assign count_next = full_now ? count : count + CW'(1);
    assign acc_next   = acc + in_ext - (sub ? old_ext : '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            acc         <= '0;
            count       <= '0;
            out_sum     <= '0;
            out_valid   <= 1'b0;
            window_full <= 1'b0;
            err         <= 1'b0;
        end else begin
            if (old_valid && !in_valid)
                err <= 1'b1;

            if (clear) begin
                acc         <= '0;
                count       <= '0;
                out_sum     <= '0;
                out_valid   <= 1'b0;
                window_full <= 1'b0;
            end else if (in_valid) begin
                if (old_valid != full_now)
                    err <= 1'b1;
                acc         <= acc_next;
                out_sum     <= acc_next;
                count       <= count_next;
                window_full <= (count_next == CW'(WINDOW));
                out_valid   <= EMIT_PARTIAL || (count_next == CW'(WINDOW));
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_minn_window_sum.sv
// Randomized and directed bench for minn_window_sum; two instances (full-only and
// partial emit) share stimulus and are checked against a queue-based window model.
module tb_minn_window_sum;
    localparam int W  = 16;
    localparam int WN = 4;
    localparam int AW = W + $clog2(WN) + 1;

    logic clk = 1'b0;
    logic rst, clear, in_valid, old_valid;
    logic signed [W-1:0]  in_data, old_data;
    logic                 ov0, ov1, wf0, wf1, er0, er1;
    logic signed [AW-1:0] sum0, sum1;

    always #5 clk = ~clk;

    minn_window_sum #(.WIDTH(W), .WINDOW(WN), .ACC_WIDTH(AW), .EMIT_PARTIAL(1'b0)) dut0 (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_data(in_data),
        .old_valid(old_valid), .old_data(old_data), .out_valid(ov0), .out_sum(sum0),
        .window_full(wf0), .err(er0));

    minn_window_sum #(.WIDTH(W), .WINDOW(WN), .ACC_WIDTH(AW), .EMIT_PARTIAL(1'b1)) dut1 (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_data(in_data),
        .old_valid(old_valid), .old_data(old_data), .out_valid(ov1), .out_sum(sum1),
        .window_full(wf1), .err(er1));

    int n_cmp = 0;
    int n_bad = 0;

    // Model: every accepted term since reset/clear, plus the drift caused by
    // departing terms the upstream failed to report.
    int     hist[$];
    longint skew;
    longint m_sum;
    logic   m_v0, m_v1, m_full, m_err;

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic longint window_sum();
        longint s = 0;
        int lo = (hist.size() > WN) ? hist.size() - WN : 0;
        for (int i = lo; i < hist.size(); i++) s += hist[i];
        return s;
    endfunction

    task automatic model_reset();
        hist.delete();
        skew = 0; m_sum = 0; m_v0 = 0; m_v1 = 0; m_full = 0;
    endtask

    task automatic step(input logic iv, input int id, input logic ov, input int od,
                        input logic clr, input logic rs);
        bit full_before;
        rst = rs; clear = clr; in_valid = iv; old_valid = ov;
        in_data = W'(id); old_data = W'(od);
        @(posedge clk);
        #1;
        if (rs) begin
            model_reset();
            m_err = 0;
        end else begin
            if (ov && !iv) m_err = 1;
            if (clr) begin
                model_reset();
            end else if (iv) begin
                full_before = hist.size() >= WN;
                if (ov && !full_before) m_err = 1;
                if (!ov && full_before) begin
                    m_err = 1;
                    skew += hist[hist.size() - WN];
                end
                hist.push_back(id);
                m_sum  = window_sum() + skew;
                m_full = hist.size() >= WN;
                m_v0   = m_full;
                m_v1   = 1;
            end else begin
                m_v0 = 0; m_v1 = 0;
            end
        end
        chk("out_valid0", ov0, m_v0);
        chk("out_valid1", ov1, m_v1);
        chk("out_sum0", sum0, m_sum);
        chk("out_sum1", sum1, m_sum);
        chk("window_full", wf0, m_full);
        chk("err", er0, m_err);
        chk("err1", er1, m_err);
    endtask

    // Legal term: departing term reported exactly when the window is full.
    task automatic term(input int d);
        bit f = hist.size() >= WN;
        step(1, d, f, f ? hist[hist.size() - WN] : 0, 0, 0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 1);
    endtask

    initial begin
        m_err = 0;
        model_reset();
        do_reset();
        idle(5);

        // Ramp: sums 10,14,18 once full; partial instance also sees 1,3,6.
        for (int i = 1; i <= 6; i++) term(i);
        chk("ramp_final", sum0, 18);
        idle(2);

        // Extremes separated by gaps.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            term(-32768);
            if (i < 3) idle(2);
        end
        chk("extreme_final", sum0, -131072);

        // clear wins over a same-cycle term.
        do_reset();
        for (int i = 1; i <= 5; i++) term(i);
        chk("pre_clear", sum0, 14);
        step(1, 9, 1, 2, 1, 0);
        for (int i = 0; i < 4; i++) term(1);
        chk("post_clear", sum0, 4);

        // Protocol errors.
        do_reset();
        term(3);
        step(0, 0, 1, 5, 0, 0);
        chk("err_orphan_old", er0, 1);
        idle(2);
        do_reset();
        term(3);
        step(1, 4, 1, 7, 0, 0);
        chk("err_early_old", sum0, 7);
        do_reset();
        for (int i = 1; i <= 4; i++) term(i);
        step(1, 5, 0, 0, 0, 0);
        chk("err_missing_old", er0, 1);
        idle(2);
        do_reset();
        chk("err_cleared", er0, 0);

        // Randomized legal traffic with gaps, clears and mid-stream resets.
        for (int i = 0; i < 600; i++) begin
            int r = $urandom_range(0, 99);
            logic signed [W-1:0] v = W'($urandom);
            if (r < 2) step($urandom_range(0, 1), int'(v), 0, 0, 0, 1);
            else if (r < 5) step($urandom_range(0, 1), int'(v), 0, 0, 1, 0);
            else if (r < 30) idle(1);
            else term(int'(v));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
